irq_req_latch: RTL and testbench



---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_req_latch_if.sv | 24 ++
 rtl/irq_sync_edge.sv | 30 +++
 rtl/irq_req_latch.sv | 95 +++++++++
 tb/tb_irq_req_latch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM encoding and helpers for the request latch
package irq_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SVC  = 2'b10
    } state_t;

    // One-hot select of a request line from its encoder index.
    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_req_latch_if.sv
// rtl/irq_req_latch_if.sv - encoder and consumer handshake bundle
interface irq_req_latch_if;
    import irq_pkg::*;

    logic [NREQ-1:0]  y_o;
    logic [IDX_W-1:0] a_i;
    logic             irq_o;
    logic             ack_i;
    logic             eoi_i;
    logic [IDX_W-1:0] svc_idx_o;
    logic             busy_o;

    // master: the latch itself; slave: encoder plus consumer
    modport master (
        output y_o, irq_o, svc_idx_o, busy_o,
        input  a_i, ack_i, eoi_i
    );

    modport slave (
        input  y_o, irq_o, svc_idx_o, busy_o,
        output a_i, ack_i, eoi_i
    );

endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-line synchroniser with rising-edge detector
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    // Shift the async line through the synchroniser; history starts low so a
    // line already high at reset release yields exactly one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~hist;

endmodule

// File: rtl/irq_req_latch.sv
// rtl/irq_req_latch.sv - request capture, masking and req/ack/eoi service handshake
module irq_req_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_in,
    input  logic [NREQ-1:0] mask_i,
    output logic [NREQ-1:0] lost_o,
    input  logic            lost_clr_i,
    irq_req_latch_if.master bus
);

    state_t           state, state_nxt;
    logic [NREQ-1:0]  level, rise;
    logic [NREQ-1:0]  pend, pend_nxt, lost_nxt;
    logic [NREQ-1:0]  y, clr;
    logic [IDX_W-1:0] svc_idx;
    logic             ack_ok;

    for (genvar i = 0; i < NREQ; i++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    assign y      = pend & ~mask_i;
    // An ack only counts while something is actually presented to the encoder.
    assign ack_ok = (state == REQ) && bus.ack_i && (y != '0);
    assign clr    = ack_ok ? idx_onehot(bus.a_i) : '0;

    // Pending/lost next state: a new edge beats a coincident clear.
    always_comb begin
        pend_nxt = pend;
        lost_nxt = lost_o;
        if (EDGE_MODE != 0) begin
            pend_nxt = rise | (pend & ~clr);
            lost_nxt = (rise & pend & ~clr) | (lost_o & ~{NREQ{lost_clr_i}});
        end else begin
            pend_nxt = level;
            lost_nxt = '0;
        end
    end

    // Pending, lost and served-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            lost_o  <= '0;
            svc_idx <= '0;
        end else begin
            pend   <= pend_nxt;
            lost_o <= lost_nxt;
            if (ack_ok) begin
                svc_idx <= bus.a_i;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake next state; a fully masked vector in REQ withdraws the request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (y != '0) state_nxt = REQ;
            REQ: begin
                if (y == '0)        state_nxt = IDLE;
                else if (bus.ack_i) state_nxt = SVC;
            end
            SVC:  if (bus.eoi_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.y_o       = y;
    assign bus.irq_o     = (state == REQ);
    assign bus.busy_o    = (state == SVC);
    assign bus.svc_idx_o = svc_idx;

endmodule

// File: tb/tb_irq_req_latch.sv
// tb/tb_irq_req_latch.sv - self-checking bench for irq_req_latch
module tb_irq_req_latch;

    localparam int S = 2;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = '0;
    logic [3:0] mask_i = '0;
    logic       lost_clr_i = 1'b0;
    logic [3:0] lost_o;
    logic [1:0] enc;

    int total = 0;
    int passed = 0;

    irq_req_latch_if bus ();

    irq_req_latch #(.SYNC_STAGES(S), .EDGE_MODE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask_i     (mask_i),
        .lost_o     (lost_o),
        .lost_clr_i (lost_clr_i),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // External 4-to-2 priority encoder, bit3 highest.
    always_comb begin
        enc = 2'd0;
        for (int i = 0; i < 4; i++) if (bus.y_o[i]) enc = 2'(i);
    end
    assign bus.a_i = enc;

    // Reference model: samples of req_in per edge, pending/lost sets, service state.
    logic [3:0] m_q[$];
    logic [3:0] m_pend, m_lost;
    logic [1:0] m_svc;
    int         m_st;

    task automatic model_reset();
        m_pend = '0;
        m_lost = '0;
        m_svc  = '0;
        m_st   = M_IDLE;
        m_q.delete();
        for (int i = 0; i <= S; i++) m_q.push_back(4'b0);
    endtask

    task automatic model_step();
        logic [3:0] nw, y, clrb;
        int top;
        bit accept;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // m_q[S] is the sample from the previous edge, so m_q[1] is S edges old.
        nw = m_q[1] & ~m_q[0];
        y = m_pend & ~mask_i;
        top = 0;
        for (int i = 0; i < 4; i++) if (y[i]) top = i;
        accept = (m_st == M_REQ) && bus.ack_i && (y != 0);
        clrb = accept ? (4'b0001 << top) : 4'b0000;
        m_lost = (m_lost & ~{4{lost_clr_i}}) | (nw & m_pend & ~clrb);
        m_pend = nw | (m_pend & ~clrb);
        if (accept) m_svc = 2'(top);
        if (m_st == M_IDLE) begin
            if (y != 0) m_st = M_REQ;
        end else if (m_st == M_REQ) begin
            if (y == 0) m_st = M_IDLE;
            else if (bus.ack_i) m_st = M_SVC;
        end else if (bus.eoi_i) begin
            m_st = M_IDLE;
        end
        m_q.push_back(req_in);
        void'(m_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0] req, mask;
        logic       ack, eoi, lc;
        logic [3:0] y;
        logic       irq, busy;
        logic [1:0] svc;
        logic [3:0] lost;
    } vec_t;

    vec_t tbl[21];

    initial begin
        bit got;

        tbl[0]  = '{4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 0, 0, 2'd0, 4'b0000};
        tbl[3]  = '{4'b1111, 4'b0000, 0, 0, 0, 4'b1111, 1, 0, 2'd0, 4'b0000};
        tbl[4]  = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0111, 0, 1, 2'd3, 4'b0000};
        tbl[5]  = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0111, 0, 1, 2'd3, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0111, 0, 0, 2'd3, 4'b0000};
        tbl[7]  = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0111, 1, 0, 2'd3, 4'b0000};
        tbl[8]  = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0111, 1, 0, 2'd3, 4'b0000};
        tbl[9]  = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0011, 0, 1, 2'd2, 4'b0000};
        tbl[10] = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0011, 0, 0, 2'd2, 4'b0000};
        tbl[11] = '{4'b1111, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 2'd2, 4'b0000};
        tbl[12] = '{4'b1111, 4'b0011, 1, 0, 0, 4'b0000, 0, 0, 2'd2, 4'b0000};
        tbl[13] = '{4'b1111, 4'b0011, 0, 0, 0, 4'b0000, 0, 0, 2'd2, 4'b0000};
        tbl[14] = '{4'b1111, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 2'd2, 4'b0000};
        tbl[15] = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0001, 0, 1, 2'd1, 4'b0000};
        tbl[16] = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0001, 0, 0, 2'd1, 4'b0000};
        tbl[17] = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0001, 1, 0, 2'd1, 4'b0000};
        tbl[18] = '{4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 2'd0, 4'b0000};
        tbl[19] = '{4'b1111, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 2'd0, 4'b0000};
        tbl[20] = '{4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000};

        model_reset();
        bus.ack_i = 1'b0;
        bus.eoi_i = 1'b0;
        req_in = 4'b1111;
        repeat (3) tick();
        check("reset_outputs", 32'({bus.y_o, bus.irq_o, bus.busy_o, bus.svc_idx_o, lost_o}), 32'd0);
        rst_n = 1'b1;

        // Directed table: reset release, priority order, masking, protocol abuse.
        for (int i = 0; i < 21; i++) begin
            req_in = tbl[i].req;
            mask_i = tbl[i].mask;
            bus.ack_i = tbl[i].ack;
            bus.eoi_i = tbl[i].eoi;
            lost_clr_i = tbl[i].lc;
            tick();
            check($sformatf("tbl%0d_y", i), 32'(bus.y_o), 32'(tbl[i].y));
            check($sformatf("tbl%0d_irq", i), 32'(bus.irq_o), 32'(tbl[i].irq));
            check($sformatf("tbl%0d_busy", i), 32'(bus.busy_o), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_svc", i), 32'(bus.svc_idx_o), 32'(tbl[i].svc));
            check($sformatf("tbl%0d_lost", i), 32'(lost_o), 32'(tbl[i].lost));
        end
        bus.ack_i = 1'b0;
        bus.eoi_i = 1'b0;

        // Loss: second edge on bit2 while still pending.
        req_in = 4'b0000;
        repeat (4) tick();
        req_in = 4'b0100; tick();
        req_in = 4'b0000; repeat (3) tick();
        check("loss_first_pend", 32'({bus.y_o, bus.irq_o}), 32'({4'b0100, 1'b1}));
        check("loss_none_yet", 32'(lost_o), 32'd0);
        req_in = 4'b0100; tick();
        req_in = 4'b0000; repeat (3) tick();
        check("loss_set", 32'(lost_o), 32'(4'b0100));
        lost_clr_i = 1'b1; tick(); lost_clr_i = 1'b0;
        check("loss_clr", 32'(lost_o), 32'd0);
        bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
        check("loss_ack", 32'({bus.svc_idx_o, bus.busy_o, bus.y_o}), 32'({2'd2, 1'b1, 4'b0000}));
        bus.eoi_i = 1'b1; tick(); bus.eoi_i = 1'b0;

        // Collision: new edge on bit3 in the same cycle as ack clears bit3.
        req_in = 4'b1000; tick();
        req_in = 4'b0000; repeat (4) tick();
        check("coll_req", 32'({bus.irq_o, bus.y_o}), 32'({1'b1, 4'b1000}));
        req_in = 4'b1000; tick();
        req_in = 4'b0000; tick();
        bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
        check("coll_svc", 32'({bus.svc_idx_o, bus.busy_o}), 32'({2'd3, 1'b1}));
        check("coll_repend", 32'(bus.y_o), 32'(4'b1000));
        check("coll_nolost", 32'(lost_o), 32'd0);
        bus.eoi_i = 1'b1; tick(); bus.eoi_i = 1'b0;
        check("coll_gap", 32'({bus.irq_o, bus.busy_o}), 32'd0);
        tick();
        check("coll_rereq", 32'(bus.irq_o), 32'd1);
        bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
        bus.eoi_i = 1'b1; tick(); bus.eoi_i = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req_in[b] = ~req_in[b];
            mask_i = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            bus.ack_i = ($urandom_range(0, 2) == 0);
            bus.eoi_i = ($urandom_range(0, 3) == 0);
            lost_clr_i = ($urandom_range(0, 15) == 0);
            tick();
            check($sformatf("rand%0d", n),
                  32'({bus.y_o, bus.irq_o, bus.busy_o, bus.svc_idx_o, lost_o}),
                  32'({m_pend & ~mask_i, m_st == M_REQ, m_st == M_SVC, m_svc, m_lost}));
        end

        // Reset asserted mid-service drops busy immediately.
        mask_i = '0; bus.ack_i = 1'b0; lost_clr_i = 1'b0;
        bus.eoi_i = 1'b1; tick(); bus.eoi_i = 1'b0;
        req_in = 4'b0000; repeat (4) tick();
        req_in = 4'b0001; tick(); req_in = 4'b0000;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = bus.irq_o;
        end
        check("svc_wait_irq", 32'(got), 32'd1);
        bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
        check("svc_busy", 32'(bus.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midsvc_reset", 32'({bus.y_o, bus.irq_o, bus.busy_o, bus.svc_idx_o, lost_o}), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
